muldiv_sequencer: RTL and testbench

- Multi-cycle sequencer for the pipeline5 execute stage. It computes MUL (low 32 bits), DIVU and REMU by driving the existing 3-bit-control ALU over many cycles.
- It owns the ALU control/operand inputs while busy and reads back the ALU result.
- The pipeline stalls on busy and collects the result through a valid/ready handshake.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_sequencer.sv | 177 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle MUL/DIVU/REMU sequencer.
package muldiv_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int ITER_COUNT = WORD_WIDTH;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REMU = 2'b10
    } op_t;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_MUL_STEP = 3'd1;
    localparam state_t ST_DIV_CMP  = 3'd2;
    localparam state_t ST_DIV_SUB  = 3'd3;
    localparam state_t ST_DONE     = 3'd4;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_GTU = 3'b010;

endpackage

// File: rtl/muldiv_sequencer.sv
// MUL/DIVU/REMU over the shared execute ALU: 33-cycle MUL (early-out with MULDIV_EARLY_OUT_EN), 65-cycle divide,
// 1-cycle for divide-by-zero/reserved op; result held in DONE until result_ready, flush aborts anywhere.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int word_width = WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [1:0]            start_op,
    input  logic [word_width-1:0] start_a,
    input  logic [word_width-1:0] start_b,
    input  logic                  flush,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [word_width-1:0] result_data,
    output logic                  busy,
    output logic [2:0]            alu_control,
    output logic [word_width-1:0] alu_src_a,
    output logic [word_width-1:0] alu_src_b,
    input  logic [word_width-1:0] alu_result
);

    localparam int              CNT_W    = $clog2(word_width);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(word_width - 1);

    state_t                  state;
    logic [1:0]              op_q;
    logic [CNT_W-1:0]        cnt;
    logic [word_width-1:0]   acc;
    logic [word_width-1:0]   mcand;
    logic [word_width-1:0]   mplier;
    logic [word_width-1:0]   rem;
    logic [word_width-1:0]   quo;
    logic [word_width-1:0]   divisor;
    logic                    lt;
    logic [word_width-1:0]   res;

    logic [word_width-1:0]   rs;
    logic [word_width-1:0]   rem_new;
    logic [word_width-1:0]   quo_new;
    logic                    mul_last;

    // Partial remainder shifted left with the next dividend bit; rem's MSB falls out as the overflow bit.
    assign rs      = {rem[word_width-2:0], quo[word_width-1]};
    assign rem_new = lt ? rs : alu_result;
    assign quo_new = {quo[word_width-2:0], ~lt};

`ifdef MULDIV_EARLY_OUT_EN
    assign mul_last = (cnt == CNT_LAST) || ((mplier >> 1) == '0);
`else
    assign mul_last = (cnt == CNT_LAST);
`endif

    assign start_ready  = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);
    assign result_valid = (state == ST_DONE);
    assign result_data  = res;

    always_comb begin
        alu_control = ALU_ADD;
        alu_src_a   = '0;
        alu_src_b   = '0;
        case (state)
            ST_MUL_STEP: begin
                alu_control = ALU_ADD;
                alu_src_a   = acc;
                alu_src_b   = mplier[0] ? mcand : '0;
            end
            ST_DIV_CMP: begin
                alu_control = ALU_GTU;
                alu_src_a   = divisor;
                alu_src_b   = rs;
            end
            ST_DIV_SUB: begin
                alu_control = ALU_SUB;
                alu_src_a   = rs;
                alu_src_b   = divisor;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            op_q    <= '0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            lt      <= 1'b0;
            res     <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_valid) begin
                        op_q    <= start_op;
                        cnt     <= '0;
                        acc     <= '0;
                        mcand   <= start_a;
                        mplier  <= start_b;
                        rem     <= '0;
                        quo     <= start_a;
                        divisor <= start_b;
                        case (start_op)
                            OP_MUL: begin
`ifdef MULDIV_EARLY_OUT_EN
                                if (start_b == '0) begin
                                    res   <= '0;
                                    state <= ST_DONE;
                                end else begin
                                    state <= ST_MUL_STEP;
                                end
`else
                                state <= ST_MUL_STEP;
`endif
                            end
                            OP_DIVU, OP_REMU: begin
                                if (start_b == '0) begin
                                    res   <= (start_op == OP_DIVU) ? '1 : start_a;
                                    state <= ST_DONE;
                                end else begin
                                    state <= ST_DIV_CMP;
                                end
                            end
                            default: begin
                                res   <= '0;
                                state <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_MUL_STEP: begin
                    acc    <= alu_result;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (mul_last) begin
                        res   <= alu_result;
                        state <= ST_DONE;
                    end
                end
                ST_DIV_CMP: begin
                    // A set overflow bit means rs is at least 2^W, so it can never be below the divisor.
                    lt    <= alu_result[0] & ~rem[word_width-1];
                    state <= ST_DIV_SUB;
                end
                ST_DIV_SUB: begin
                    rem <= rem_new;
                    quo <= quo_new;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        res   <= (op_q == OP_DIVU) ? quo_new : rem_new;
                        state <= ST_DONE;
                    end else begin
                        state <= ST_DIV_CMP;
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer with a behavioural 3-bit ALU beside it.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_valid;
    logic        start_ready;
    logic [1:0]  start_op;
    logic [31:0] start_a;
    logic [31:0] start_b;
    logic        flush;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result_data;
    logic        busy;
    logic [2:0]  alu_control;
    logic [31:0] alu_src_a;
    logic [31:0] alu_src_b;
    logic [31:0] alu_result;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.word_width(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .start_op     (start_op),
        .start_a      (start_a),
        .start_b      (start_b),
        .flush        (flush),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_data  (result_data),
        .busy         (busy),
        .alu_control  (alu_control),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_result   (alu_result)
    );

    always_comb begin
        alu_result = '0;
        case (alu_control)
            3'b000:  alu_result = alu_src_a + alu_src_b;
            3'b001:  alu_result = alu_src_a - alu_src_b;
            3'b010:  alu_result = {31'b0, (alu_src_a > alu_src_b)};
            default: alu_result = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int mul_lat(input logic [31:0] b);
        int lat;
        lat = 33;
`ifdef MULDIV_EARLY_OUT_EN
        lat = 1;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) lat = i + 2;
        end
`endif
        return lat;
    endfunction

    // Issue one request, measure cycles from accept to result_valid, optionally stall the consumer, then handshake.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input int hold);
        int  lat;
        logic busy_ok;
        logic stable_ok;
        @(negedge clk);
        check({tag, " start_ready"}, {31'b0, start_ready}, 32'd1);
        start_valid = 1'b1;
        start_op    = op;
        start_a     = a;
        start_b     = b;
        @(posedge clk);
        #1 start_valid = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (!busy) busy_ok = 1'b0;
        end while (!result_valid && lat < 200);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy"}, {31'b0, busy_ok}, 32'd1);
        check({tag, " data"}, result_data, exp);
        stable_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!result_valid || result_data !== exp) stable_ok = 1'b0;
        end
        if (hold > 0) check({tag, " held"}, {31'b0, stable_ok}, 32'd1);
        result_ready = 1'b1;
        @(posedge clk);
        #1 result_ready = 1'b0;
        @(negedge clk);
        check({tag, " valid drop"}, {31'b0, result_valid}, 32'd0);
        check({tag, " idle"}, {31'b0, start_ready}, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic seen;
        reset        = 1'b1;
        start_valid  = 1'b0;
        start_op     = 2'b00;
        start_a      = '0;
        start_b      = '0;
        flush        = 1'b0;
        result_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst valid", {31'b0, result_valid}, 32'd0);
        check("rst busy", {31'b0, busy}, 32'd0);
        check("rst data", result_data, 32'd0);
        check("rst aluctl", {29'b0, alu_control}, 32'd0);
        check("rst srca", alu_src_a, 32'd0);
        check("rst srcb", alu_src_b, 32'd0);
        reset = 1'b0;

        run_op("mul 7*6",     2'b00, 32'd7,        32'd6,        32'd42,        mul_lat(32'd6),        0);
        run_op("mul ff*ff",   2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,  mul_lat(32'hFFFFFFFF), 0);
        run_op("mul 1e16",    2'b00, 32'h00010000, 32'h00010000, 32'h00000000,  mul_lat(32'h00010000), 0);
        run_op("divu 100/7",  2'b01, 32'd100,      32'd7,        32'd14,        65, 0);
        run_op("remu 100/7",  2'b10, 32'd100,      32'd7,        32'd2,         65, 0);
        run_op("divu ovf",    2'b01, 32'hFFFFFFFF, 32'h80000001, 32'd1,         65, 0);
        run_op("remu ovf",    2'b10, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE,  65, 0);
        run_op("divu by1",    2'b01, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF,  65, 0);
        run_op("divu by0",    2'b01, 32'd5,        32'd0,        32'hFFFFFFFF,  1,  0);
        run_op("remu by0",    2'b10, 32'd5,        32'd0,        32'd5,         1,  0);
        run_op("op11",        2'b11, 32'd9,        32'd3,        32'd0,         1,  0);
        run_op("hold",        2'b00, 32'd1234,     32'd5678,     32'd7006652,   mul_lat(32'd5678),     5);

        // flush part-way through a divide
        @(negedge clk);
        start_valid = 1'b1;
        start_op    = 2'b01;
        start_a     = 32'd1000;
        start_b     = 32'd3;
        @(posedge clk);
        #1 start_valid = 1'b0;
        for (n = 1; n <= 10; n++) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush ready", {31'b0, start_ready}, 32'd1);
        check("flush busy", {31'b0, busy}, 32'd0);
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (result_valid) seen = 1'b1;
        end
        check("flush no result", {31'b0, seen}, 32'd0);

        // flush beats start_valid in IDLE
        @(negedge clk);
        start_valid = 1'b1;
        start_op    = 2'b00;
        start_a     = 32'd3;
        start_b     = 32'd3;
        flush       = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("flush blocks accept", {31'b0, busy}, 32'd0);

        // reset part-way through a multiply
        @(negedge clk);
        start_valid = 1'b1;
        start_op    = 2'b00;
        start_a     = 32'h12345678;
        start_b     = 32'h9ABCDEF1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        for (n = 1; n <= 20; n++) @(negedge clk);
        check("pre-reset busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid rst valid", {31'b0, result_valid}, 32'd0);
        check("mid rst busy", {31'b0, busy}, 32'd0);
        check("mid rst data", result_data, 32'd0);
        check("mid rst aluctl", {29'b0, alu_control}, 32'd0);
        check("mid rst srca", alu_src_a, 32'd0);
        check("mid rst srcb", alu_src_b, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid) seen = 1'b1;
        end
        check("mid rst no result", {31'b0, seen}, 32'd0);

        run_op("post rst mul", 2'b00, 32'd3, 32'd5, 32'd15, mul_lat(32'd5), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
